// File: rtl/fir_mac_pipe_if.sv
// Stream-side bundle for fir_mac_pipe: operand pair input and frame result output.
// The master drives pairs and accepts results; the slave (the engine) does the reverse.
interface fir_mac_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_ovf;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_count
  );
endinterface

// File: rtl/fir_mac_pipe.sv
// Two-stage multiply-accumulate engine: stage 1 registers the full product,
// stage 2 accumulates one frame and hands the sum to a single-entry output register.
module fir_mac_pipe #(
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 32,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b0,
  parameter int CNT_W    = 8
) (
  input  logic axis_clk,
  input  logic reset,
  input  logic flush,
  output logic busy,
  fir_mac_pipe_if.slave bus
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic              s1_valid;
  logic              s1_last;
  logic [PROD_W-1:0] s1_prod;

  logic [ACC_W-1:0]  acc;
  logic              ovf_sticky;
  logic [CNT_W-1:0]  count;

  logic              stall;
  logic              accept;
  logic              s2_fire;
  logic [PROD_W-1:0] ext_a;
  logic [PROD_W-1:0] ext_b;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  prod_t;
  logic [ACC_W:0]    sum;
  logic              ovf;
  logic [ACC_W-1:0]  acc_next;

  // Only a finished frame waiting on a full output register can block the pipe.
  assign stall        = s1_valid && s1_last && bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall || flush;
  assign accept       = bus.in_valid && bus.in_ready && !flush;
  assign s2_fire      = s1_valid && !stall && !flush;
  assign busy         = s1_valid || (count != '0);

  // Extending both operands to the product width makes one unsigned multiply
  // yield the correct low PROD_W bits for either signedness.
  always_comb begin
    if (SIGNED) begin
      ext_a = {{DATA_W{bus.in_a[DATA_W-1]}}, bus.in_a};
      ext_b = {{DATA_W{bus.in_b[DATA_W-1]}}, bus.in_b};
    end else begin
      ext_a = {{DATA_W{1'b0}}, bus.in_a};
      ext_b = {{DATA_W{1'b0}}, bus.in_b};
    end
  end

  assign prod   = ext_a * ext_b;
  assign prod_t = s1_prod[ACC_W-1:0];
  assign sum    = {1'b0, acc} + {1'b0, prod_t};

  generate
    if (ACC_W < PROD_W) begin : g_trunc
      logic unused_prod_hi;
      assign unused_prod_hi = ^s1_prod[PROD_W-1:ACC_W];
    end
  endgenerate

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ovf      = 1'b0;
    acc_next = sum[ACC_W-1:0];
    if (SIGNED) begin
      ovf = (acc[ACC_W-1] == prod_t[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    end else begin
      ovf = sum[ACC_W];
    end
    if (SATURATE && ovf) begin
      if (SIGNED) acc_next = acc[ACC_W-1] ? SMIN : SMAX;
      else        acc_next = '1;
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge axis_clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_last  <= bus.in_last;
      s1_prod  <= prod;
    end else if (s2_fire) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (reset) begin
      acc           <= '0;
      ovf_sticky    <= 1'b0;
      count         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ovf   <= 1'b0;
      bus.out_count <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      if (flush) begin
        acc        <= '0;
        ovf_sticky <= 1'b0;
        count      <= '0;
      end else if (s2_fire) begin
        if (s1_last) begin
          // A new result wins over a same-edge drain of the previous one.
          bus.out_data  <= acc_next;
          bus.out_ovf   <= ovf_sticky | ovf;
          bus.out_count <= count + 1'b1;
          bus.out_valid <= 1'b1;
          acc           <= '0;
          ovf_sticky    <= 1'b0;
          count         <= '0;
        end else begin
          acc        <= acc_next;
          ovf_sticky <= ovf_sticky | ovf;
          count      <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_pipe.sv
// Directed bench: three engine variants (unsigned wrap, signed wrap, signed saturate
// with a 2-bit counter) share one stimulus stream and are checked against hand values.
module tb_fir_mac_pipe;

  logic        axis_clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        busy_u, busy_s, busy_t;

  int vectors     = 0;
  int miscompares = 0;

  always #5 axis_clk = ~axis_clk;

  fir_mac_pipe_if #(.DATA_W(32), .ACC_W(32), .CNT_W(8)) if_u ();
  fir_mac_pipe_if #(.DATA_W(32), .ACC_W(32), .CNT_W(8)) if_s ();
  fir_mac_pipe_if #(.DATA_W(32), .ACC_W(32), .CNT_W(2)) if_t ();

  assign if_u.in_valid = in_valid;  assign if_s.in_valid = in_valid;  assign if_t.in_valid = in_valid;
  assign if_u.in_a     = in_a;      assign if_s.in_a     = in_a;      assign if_t.in_a     = in_a;
  assign if_u.in_b     = in_b;      assign if_s.in_b     = in_b;      assign if_t.in_b     = in_b;
  assign if_u.in_last  = in_last;   assign if_s.in_last  = in_last;   assign if_t.in_last  = in_last;
  assign if_u.out_ready = out_ready; assign if_s.out_ready = out_ready; assign if_t.out_ready = out_ready;

  fir_mac_pipe #(.DATA_W(32), .ACC_W(32), .SIGNED(1'b0), .SATURATE(1'b0), .CNT_W(8)) u_uns (
    .axis_clk(axis_clk), .reset(reset), .flush(flush), .busy(busy_u), .bus(if_u.slave));
  fir_mac_pipe #(.DATA_W(32), .ACC_W(32), .SIGNED(1'b1), .SATURATE(1'b0), .CNT_W(8)) u_sgn (
    .axis_clk(axis_clk), .reset(reset), .flush(flush), .busy(busy_s), .bus(if_s.slave));
  fir_mac_pipe #(.DATA_W(32), .ACC_W(32), .SIGNED(1'b1), .SATURATE(1'b1), .CNT_W(2)) u_sat (
    .axis_clk(axis_clk), .reset(reset), .flush(flush), .busy(busy_t), .bus(if_t.slave));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    @(negedge axis_clk);
    while (!if_u.in_ready && n < 50) begin
      @(negedge axis_clk);
      n++;
    end
    check("send_accept", 32'(if_u.in_ready), 1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    @(negedge axis_clk);
    while (!if_u.out_valid && n < 50) begin
      @(negedge axis_clk);
      n++;
    end
    check("out_wait", 32'(if_u.out_valid), 1);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b1;
    step();
    step();
    @(negedge axis_clk);
    check("rst_in_ready",  32'(if_u.in_ready), 1);
    check("rst_out_valid", 32'(if_u.out_valid), 0);
    check("rst_out_data",  if_u.out_data, 0);
    check("rst_out_ovf",   32'(if_u.out_ovf), 0);
    check("rst_out_count", 32'(if_u.out_count), 0);
    check("rst_busy",      32'(busy_u), 0);
    reset = 1'b0;
    step();

    // Unsigned basic frame and two-cycle latency
    send(1, 2, 1'b0);
    send(3, 4, 1'b0);
    send(5, 6, 1'b1);
    @(negedge axis_clk);
    check("t1_lat_valid_early", 32'(if_u.out_valid), 0);
    check("t1_busy_s1",         32'(busy_u), 1);
    @(negedge axis_clk);
    check("t1_lat_valid", 32'(if_u.out_valid), 1);
    check("t1_data_u",    if_u.out_data, 44);
    check("t1_count_u",   32'(if_u.out_count), 3);
    check("t1_ovf_u",     32'(if_u.out_ovf), 0);
    check("t1_data_s",    if_s.out_data, 44);
    check("t1_count_t",   32'(if_t.out_count), 3);
    step();

    // Signed frame; the unsigned variant sees a carry out on the second term
    send(-3, 7, 1'b0);
    send(2, -5, 1'b1);
    wait_out();
    check("t2_data_s",  if_s.out_data, 32'hFFFF_FFE1);
    check("t2_ovf_s",   32'(if_s.out_ovf), 0);
    check("t2_data_t",  if_t.out_data, 32'hFFFF_FFE1);
    check("t2_ovf_t",   32'(if_t.out_ovf), 0);
    check("t2_data_u",  if_u.out_data, 32'hFFFF_FFE1);
    check("t2_ovf_u",   32'(if_u.out_ovf), 1);
    check("t2_count_s", 32'(if_s.out_count), 2);
    step();

    // Single-term frame proves the accumulator was cleared
    send(4, 4, 1'b1);
    wait_out();
    check("t3_data_s",  if_s.out_data, 16);
    check("t3_data_u",  if_u.out_data, 16);
    check("t3_count_s", 32'(if_s.out_count), 1);
    check("t3_ovf_u",   32'(if_u.out_ovf), 0);
    step();

    // Signed overflow: wrap vs saturate
    send(32'h4000_0000, 1, 1'b0);
    send(32'h4000_0000, 1, 1'b1);
    wait_out();
    check("t4_data_s", if_s.out_data, 32'h8000_0000);
    check("t4_ovf_s",  32'(if_s.out_ovf), 1);
    check("t4_data_t", if_t.out_data, 32'h7FFF_FFFF);
    check("t4_ovf_t",  32'(if_t.out_ovf), 1);
    check("t4_data_u", if_u.out_data, 32'h8000_0000);
    check("t4_ovf_u",  32'(if_u.out_ovf), 0);
    step();

    // Backpressure: two 2-term frames against a stalled consumer
    out_ready = 1'b0;
    send(1, 1, 1'b0);
    send(2, 2, 1'b1);
    send(3, 3, 1'b0);
    send(4, 4, 1'b1);
    @(negedge axis_clk);
    check("t5_stall_ready", 32'(if_u.in_ready), 0);
    check("t5_hold_valid",  32'(if_u.out_valid), 1);
    check("t5_hold_data",   if_s.out_data, 5);
    check("t5_hold_count",  32'(if_s.out_count), 2);
    step();
    @(negedge axis_clk);
    check("t5_stall_ready2", 32'(if_u.in_ready), 0);
    check("t5_hold_data2",   if_s.out_data, 5);
    step();
    out_ready = 1'b1;
    @(negedge axis_clk);
    check("t5_release_ready", 32'(if_u.in_ready), 1);
    check("t5_first_data",    if_s.out_data, 5);
    step();
    @(negedge axis_clk);
    check("t5_second_valid", 32'(if_u.out_valid), 1);
    check("t5_second_data",  if_s.out_data, 25);
    check("t5_second_count", 32'(if_s.out_count), 2);
    step();
    @(negedge axis_clk);
    check("t5_drained", 32'(if_u.out_valid), 0);
    step();

    // Five-term frame: the 2-bit counter wraps to 1
    for (int i = 0; i < 5; i++) send(1, 1, (i == 4));
    wait_out();
    check("t6_data_u",  if_u.out_data, 5);
    check("t6_count_u", 32'(if_u.out_count), 5);
    check("t6_count_t", 32'(if_t.out_count), 1);
    step();

    // Flush mid-frame drops partial sum and the pair presented with it
    send(10, 10, 1'b0);
    send(1, 1, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_a = 7; in_b = 7; in_last = 1'b1;
    @(negedge axis_clk);
    check("t7_busy_pre", 32'(busy_u), 1);
    step();
    flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge axis_clk);
    check("t7_busy_post",  32'(busy_u), 0);
    check("t7_ready_post", 32'(if_u.in_ready), 1);
    check("t7_no_result",  32'(if_u.out_valid), 0);
    step();
    send(2, 3, 1'b1);
    wait_out();
    check("t7_data",  if_s.out_data, 6);
    check("t7_count", 32'(if_s.out_count), 1);
    check("t7_ovf",   32'(if_s.out_ovf), 0);
    step();

    // Reset with stage 1 and the output register both occupied
    out_ready = 1'b0;
    send(1, 1, 1'b1);
    send(5, 5, 1'b0);
    @(negedge axis_clk);
    check("t8_pre_valid", 32'(if_u.out_valid), 1);
    check("t8_pre_busy",  32'(busy_u), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge axis_clk);
    check("t8_out_valid", 32'(if_u.out_valid), 0);
    check("t8_out_data",  if_u.out_data, 0);
    check("t8_out_count", 32'(if_u.out_count), 0);
    check("t8_out_ovf",   32'(if_u.out_ovf), 0);
    check("t8_busy",      32'(busy_u), 0);
    check("t8_in_ready",  32'(if_u.in_ready), 1);
    step();
    send(5, 5, 1'b1);
    wait_out();
    check("t8_data",  if_s.out_data, 25);
    check("t8_count", 32'(if_s.out_count), 1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
